// File: rtl/synchronize_bus.sv
// ============================================================================
// Module  : synchronize_bus
// Brief   : Multi-bit CDC synchronizer with optional per-bit glitch filter
//           (compile with SYNC_GLITCH_FILTER_EN) and registered edge pulses.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module synchronize_bus #(
    parameter int               WIDTH         = 8,
    parameter int               STAGES        = 2,
    parameter int               FILTER_CYCLES = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE   = {WIDTH{1'b0}}
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] datain,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic             change_any
);

    if (STAGES < 2) begin : g_chk_stages
        $error("synchronize_bus: STAGES must be >= 2");
    end

    if (FILTER_CYCLES < 1) begin : g_chk_filter
`ifdef SYNC_GLITCH_FILTER_EN
        $error("synchronize_bus: FILTER_CYCLES must be >= 1");
`endif
    end

    logic [WIDTH-1:0] stage_q [STAGES];
    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] rise_d;
    logic [WIDTH-1:0] fall_d;
    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] fall_q;
    logic             change_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < STAGES; k++) begin
                stage_q[k] <= RESET_VALUE;
            end
        end else begin
            stage_q[0] <= datain;
            for (int k = 1; k < STAGES; k++) begin
                stage_q[k] <= stage_q[k-1];
            end
        end
    end

    assign sync = stage_q[STAGES-1];

`ifdef SYNC_GLITCH_FILTER_EN
    localparam int              C_CNT_W   = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
    localparam logic [C_CNT_W-1:0] C_CNT_MAX = C_CNT_W'(FILTER_CYCLES - 1);

    logic [C_CNT_W-1:0] cnt_q [WIDTH];
    logic [C_CNT_W-1:0] cnt_d [WIDTH];
    logic [WIDTH-1:0]   result_q;
    logic [WIDTH-1:0]   result_d;

    // Pulses are computed together with the result update so they land in
    // the first cycle the new level is visible.
    always_comb begin
        result_d = result_q;
        rise_d   = '0;
        fall_d   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync[i] == result_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == C_CNT_MAX) begin
                result_d[i] = sync[i];
                cnt_d[i]    = '0;
                rise_d[i]   = sync[i];
                fall_d[i]   = ~sync[i];
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            result_q <= RESET_VALUE;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            result_q <= result_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign result = result_q;
`else
    // Look one stage ahead so the pulse register lines up with the last stage.
    assign rise_d = stage_q[STAGES-2] & ~stage_q[STAGES-1];
    assign fall_d = ~stage_q[STAGES-2] & stage_q[STAGES-1];
    assign result = sync;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rise_q   <= '0;
            fall_q   <= '0;
            change_q <= 1'b0;
        end else begin
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            change_q <= |(rise_d | fall_d);
        end
    end

    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign change_any = change_q;

endmodule

`default_nettype wire
